// File: rtl/alu_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue_if : request and result channels of the ALU issue stage          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface alu_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_aluop;
   logic [5:0]  in_funct;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_illegal;
   logic        out_div0;

   modport master (
      output in_valid, in_aluop, in_funct, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_illegal, out_div0
   );

   modport slave (
      input  in_valid, in_aluop, in_funct, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_illegal, out_div0
   );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_issue : decodes ALU ops, holds ALU inputs, captures and hands off result|
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module alu_issue #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_if.slave        bus,
   input  logic              flush,
   output logic [3:0]        alu_op,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   input  logic [31:0]       alu_c,
   input  logic              alu_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] c_op_add  = 4'd0;
   localparam logic [3:0] c_op_sub  = 4'd1;
   localparam logic [3:0] c_op_mul  = 4'd2;
   localparam logic [3:0] c_op_div  = 4'd3;
   localparam logic [3:0] c_op_and  = 4'd4;
   localparam logic [3:0] c_op_or   = 4'd5;
   localparam logic [3:0] c_op_xor  = 4'd6;
   localparam logic [3:0] c_op_none = 4'd7;
   localparam logic [3:0] c_md_cnt  = 4'(MULDIV_CYCLES);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_alu_op;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic        r_illegal;
   logic        r_div0;
   logic        r_out_valid;
   logic [31:0] r_out_result;
   logic        r_out_zero;
   logic        r_out_illegal;
   logic        r_out_div0;

   logic [3:0]  w_op;
   logic        w_illegal;
   logic        w_div0;
   logic [3:0]  w_load_cnt;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_force_zero;

   always_comb begin
      w_op      = c_op_none;
      w_illegal = 1'b0;
      case (bus.in_aluop)
         2'b00: w_op = c_op_add;
         2'b01: w_op = c_op_sub;
         2'b10: begin
            case (bus.in_funct)
               6'h20, 6'h21: w_op = c_op_add;
               6'h22, 6'h23: w_op = c_op_sub;
               6'h18:        w_op = c_op_mul;
               6'h1A:        w_op = c_op_div;
               6'h24:        w_op = c_op_and;
               6'h25:        w_op = c_op_or;
               6'h26:        w_op = c_op_xor;
               default: begin
                  w_op      = c_op_none;
                  w_illegal = 1'b1;
               end
            endcase
         end
         default: begin
            w_op      = c_op_none;
            w_illegal = 1'b1;
         end
      endcase
   end

   // A zero divisor short-circuits the multi-cycle hold: the result is forced anyway.
   assign w_div0       = (w_op == c_op_div) && (bus.in_b == 32'd0);
   assign w_load_cnt   = (((w_op == c_op_mul) || (w_op == c_op_div)) && !w_div0) ? c_md_cnt : 4'd1;
   assign w_in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
   assign w_accept     = bus.in_valid && w_in_ready && !flush;
   assign w_force_zero = r_illegal || r_div0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 4'd0;
         r_alu_op      <= 4'd0;
         r_alu_a       <= 32'd0;
         r_alu_b       <= 32'd0;
         r_illegal     <= 1'b0;
         r_div0        <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_result  <= 32'd0;
         r_out_zero    <= 1'b0;
         r_out_illegal <= 1'b0;
         r_out_div0    <= 1'b0;
      end else if (flush) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_EXEC: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_out_result  <= w_force_zero ? 32'd0 : alu_c;
                  r_out_zero    <= w_force_zero ? 1'b1 : alu_zero;
                  r_out_illegal <= r_illegal;
                  r_out_div0    <= r_div0;
                  r_out_valid   <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         // Accept overrides the DONE->IDLE step above for back-to-back issue.
         if (w_accept) begin
            r_alu_op    <= w_op;
            r_alu_a     <= bus.in_a;
            r_alu_b     <= bus.in_b;
            r_illegal   <= w_illegal;
            r_div0      <= w_div0;
            r_cnt       <= w_load_cnt;
            r_out_valid <= 1'b0;
            r_state     <= S_EXEC;
         end
      end
   end

   assign alu_op          = r_alu_op;
   assign alu_a           = r_alu_a;
   assign alu_b           = r_alu_b;
   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_result  = r_out_result;
   assign bus.out_zero    = r_out_zero;
   assign bus.out_illegal = r_out_illegal;
   assign bus.out_div0    = r_out_div0;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_issue : scoreboard bench for alu_issue with a behavioural ALU       |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_alu_issue;
   localparam int c_md = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_c;
   logic        alu_zero;

   alu_issue_if bus ();

   alu_issue #(.MULDIV_CYCLES(c_md)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .flush    (flush),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_c    (alu_c),
      .alu_zero (alu_zero)
   );

   always #5 clk = ~clk;

   // Stand-in ALU; a zero divisor returns junk the DUT must discard.
   always_comb begin
      alu_c = 32'd0;
      case (alu_op)
         4'd0: alu_c = alu_a + alu_b;
         4'd1: alu_c = alu_a - alu_b;
         4'd2: alu_c = alu_a * alu_b;
         4'd3: alu_c = (alu_b == 32'd0) ? 32'hDEAD_BEEF : alu_a / alu_b;
         4'd4: alu_c = alu_a & alu_b;
         4'd5: alu_c = alu_a | alu_b;
         4'd6: alu_c = alu_a ^ alu_b;
         default: alu_c = 32'd0;
      endcase
   end
   assign alu_zero = (alu_c == 32'd0);

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.res = 32'd0; e.ill = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0;
      if (op == 2'b00)      e.res = a + b;
      else if (op == 2'b01) e.res = a - b;
      else if (op == 2'b11) e.ill = 1'b1;
      else begin
         case (f)
            6'h20, 6'h21: e.res = a + b;
            6'h22, 6'h23: e.res = a - b;
            6'h18: begin e.res = a * b; e.lat = c_md; end
            6'h1A: begin
               if (b == 32'd0) e.dz = 1'b1;
               else begin e.res = a / b; e.lat = c_md; end
            end
            6'h24: e.res = a & b;
            6'h25: e.res = a | b;
            6'h26: e.res = a ^ b;
            default: e.ill = 1'b1;
         endcase
      end
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   // Result monitor: a handshake seen here completes on the next rising edge.
   logic prev_v = 1'b0;
   int   vcyc   = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (bus.out_valid && !prev_v) vcyc = cyc;
         prev_v = bus.out_valid;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("result",  bus.out_result,  mon_e.res);
               check("zero",    bus.out_zero,    mon_e.zero);
               check("illegal", bus.out_illegal, mon_e.ill);
               check("div0",    bus.out_div0,    mon_e.dz);
               check("latency", vcyc - mon_e.acc, mon_e.lat);
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   ok;
      e = model(op, f, a, b);
      bus.in_valid = 1'b1;
      bus.in_aluop = op;
      bus.in_funct = f;
      bus.in_a     = a;
      bus.in_b     = b;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) begin
         check("send_timeout", 64'd0, 64'd1);
         bus.in_valid = 1'b0;
         return;
      end
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
      sb.delete();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
      check("wait_valid", bus.out_valid, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_aluop  = 2'b00;
      bus.in_funct  = 6'h00;
      bus.in_a      = 32'd0;
      bus.in_b      = 32'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_result", bus.out_result, 0);
      check("rst_flags", {bus.out_zero, bus.out_illegal, bus.out_div0}, 0);
      check("rst_alu", {alu_op, alu_a, alu_b}, 0);
      @(posedge clk); #1;

      send(2'b10, 6'h20, 32'd5, 32'd7);
      check("add_alu_op", alu_op, 0);
      check("add_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
      drain();

      send(2'b01, 6'h00, 32'd9, 32'd9);
      drain();

      send(2'b10, 6'h1A, 32'd100, 32'd7);
      for (int k = 0; k < c_md; k++) begin
         @(negedge clk);
         check("div_hold_op", alu_op, 3);
         check("div_hold_ab", {alu_a, alu_b}, {32'd100, 32'd7});
         check("div_no_valid", bus.out_valid, 0);
      end
      drain();

      send(2'b10, 6'h1A, 32'd100, 32'd0);
      drain();
      send(2'b10, 6'h3F, 32'd3, 32'd4);
      check("ill_alu_op", alu_op, 7);
      drain();
      send(2'b11, 6'h20, 32'd3, 32'd4);
      drain();

      // Back-to-back stream with out_ready held high.
      send(2'b10, 6'h18, 32'd6, 32'd7);
      send(2'b10, 6'h24, 32'hFF00_FF00, 32'h0F0F_0F0F);
      send(2'b10, 6'h26, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      send(2'b10, 6'h21, 32'hFFFF_FFFF, 32'd1);
      send(2'b10, 6'h23, 32'd3, 32'd5);
      send(2'b10, 6'h22, 32'd42, 32'd42);
      send(2'b00, 6'h3F, 32'd1000, 32'd24);
      drain();

      // Stall in DONE, then release with a new op on the same edge.
      bus.out_ready = 1'b0;
      send(2'b10, 6'h25, 32'h0000_00F0, 32'h0000_000F);
      wait_valid();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_valid", bus.out_valid, 1);
         check("stall_result", bus.out_result, 32'hFF);
         check("stall_in_ready", bus.in_ready, 0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      send(2'b00, 6'h00, 32'd1, 32'd2);
      check("b2b_exec", bus.out_valid, 0);
      check("b2b_alu_a", alu_a, 1);
      drain();

      // Flush in the second EXEC cycle of a multiply.
      bus.in_valid = 1'b1; bus.in_aluop = 2'b10; bus.in_funct = 6'h18;
      bus.in_a = 32'd3; bus.in_b = 32'd4;
      @(negedge clk);
      check("fl_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("fl_alu_op", alu_op, 2);
      @(posedge clk); #1;
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_a = 32'd99;
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      check("fl_out_valid", bus.out_valid, 0);
      check("fl_idle", bus.in_ready, 1);
      check("fl_no_accept", alu_a, 3);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("fl_quiet", bus.out_valid, 0);
      end
      @(posedge clk); #1;

      // Reset while holding a result in DONE.
      bus.out_ready = 1'b0;
      send(2'b01, 6'h00, 32'd50, 32'd8);
      wait_valid();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      check("rst2_out_valid", bus.out_valid, 0);
      check("rst2_out", {bus.out_result, bus.out_zero, bus.out_illegal, bus.out_div0}, 0);
      check("rst2_alu", {alu_op, alu_a, alu_b}, 0);
      check("rst2_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;

      send(2'b10, 6'h20, 32'd20, 32'd22);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Sequencing front end for the datapath ALU. Accepts decoded instruction fields over a valid/ready handshake, translates the ALUOp class and funct into the 4-bit ALU operation code, and drives the operands and op into the combinational ALU. It holds those inputs for a programmable number of cycles on multiply/divide, then captures the ALU result and zero flag and presents them downstream on a second valid/ready handshake.

## Interface
- MULDIV_CYCLES, 4, cycles the ALU inputs are held stable for op 2 (mul) and op 3 (div); legal range 1..15
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  upstream request
- in_ready  out  1  block can accept on this edge
- in_aluop  in  2  00 add, 01 sub, 10 decode from funct, 11 reserved
- in_funct  in  6  R-type funct field
- in_a  in  32  operand A (rs value)
- in_b  in  32  operand B (rt value or extended immediate, already muxed)
- flush  in  1  discard any in-flight operation
- alu_op  out  4  op code to the ALU: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 none (ALU returns 0)
- alu_a, alu_b  out  32 each  ALU operands
- alu_c  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  captured result
- out_zero  out  1  captured zero flag
- out_illegal  out  1  op was unsupported; result is 0
- out_div0  out  1  divide by zero; result is forced to 0

## Operation
- Decode:
  - aluop 00 → 0; 01 → 1; 11 → 7 with illegal.
  - aluop 10, by funct: 0x20/0x21 → 0, 0x22/0x23 → 1, 0x18 → 2, 0x1A → 3, 0x24 → 4, 0x25 → 5, 0x26 → 6, any other → 7 with illegal.
- FSM states:
  - IDLE: in_ready=1. On an accept (in_valid & in_ready), register alu_op, alu_a, alu_b and the flags, then go to EXEC. The cycle counter loads 1 for ops 0,1,4,5,6,7 and loads MULDIV_CYCLES for ops 2,3.
  - EXEC: alu_op, alu_a and alu_b stay stable. The counter decrements each edge. On the edge where the counter equals 1, capture alu_c and alu_zero into the out_* registers and go to DONE.
  - DONE: out_valid=1. out_result, out_zero and the flags stay stable until out_ready.
    - in_ready = out_ready in this state.
    - out_ready & in_valid: accept the new op and go to EXEC (back-to-back).
    - out_ready & !in_valid: go to IDLE.
- Divide by zero: op 3 with in_b==0 sets div0 at accept and the counter loads 1. At capture, out_result=0 and out_zero=1; alu_c is ignored.
- Illegal op: out_result=0, out_zero=1, out_illegal=1. It completes like a single-cycle op.
- ALU inputs stay at their last values in IDLE and DONE; they are not cleared.

## Timing
- Reset: state IDLE, counter 0, and every output 0 (alu_op, alu_a, alu_b, out_valid, out_result, out_zero, out_illegal, out_div0). in_ready is 1 on the first cycle after reset.
- Latency, measured from the accept edge N:
  - single-cycle ops: capture at N+1, out_valid high from N+1.
  - mul/div: capture at N+MULDIV_CYCLES.
- Throughput: one op per 2 cycles when out_ready is held high; one per MULDIV_CYCLES+1 for mul/div.
- flush: FSM to IDLE and out_valid=0 on the same edge. flush has priority over accept and capture; an in_valid during flush is not accepted. out_* values are kept, but out_valid drops.
- rst has priority over flush and everything else. Reset during EXEC or DONE abandons the op with no output.
- out_valid depends only on registered state. in_ready depends combinationally on state and out_ready.

## Test plan
- Reset, then accept aluop=10, funct=0x20, a=5, b=7 → alu_op=0 at N+1; out_valid=1 at N+1 with out_result=12, out_zero=0.
- aluop=01, a=9, b=9 → out_result=0, out_zero=1, latency 1.
- funct=0x1A, a=100, b=7, MULDIV_CYCLES=4 → alu_op=3 and alu_a/alu_b stable for 4 cycles; out_result=14 at N+4. Same op with b=0 → out_div0=1, out_result=0, latency 1.
- funct=0x3F → alu_op=7, out_illegal=1, out_result=0. Then aluop=11 → out_illegal=1.
- Hold out_ready=0 for 3 cycles in DONE → out_* stable and in_ready=0. Release together with in_valid carrying a new op → back-to-back accept with no IDLE cycle.
- Assert flush in the 2nd cycle of a mul EXEC → out_valid stays 0 and the FSM is IDLE next cycle. Assert rst in DONE → all outputs 0 on the next edge.
